// File: rtl/sr_pkg.sv
// Shared types and command encodings for the SR flip-flop and its upstream command stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_pkg;

    // Per-channel debounce state. *_LO and *_HI give the accepted level.
    // WAIT_* means a change is being qualified.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } deb_state_t;

    // {s, r} command encodings. The flip-flop's case decode uses the same values.
    localparam logic [1:0] SR_CMD_SET  = 2'b10;
    localparam logic [1:0] SR_CMD_RST  = 2'b01;
    localparam logic [1:0] SR_CMD_HOLD = 2'b00;

endpackage

// File: rtl/sr_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, and a rising-edge strobe.
// Latency: the strobe rises DEBOUNCE_CYCLES+2 edges after the raw input settles high.
// Backpressure: none; the strobe is a single-cycle, fire-and-forget signal.
//
// Ports: clk, reset (async active-low), btn_raw (async bouncing input),
//        lvl (debounced level), rise (1-cycle strobe on an accepted low->high change).
module sr_debounce
    import sr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic lvl,
    output logic rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             sync_bit;

    assign sync_bit = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (sync_bit) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_bit) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!sync_bit) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (sync_bit) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // A release is accepted silently. Only presses generate commands.
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    // The level is decoded from the state register, so it changes on the same edge as the strobe.
    assign lvl  = (state_q == IDLE_HI) || (state_q == WAIT_LO);
    assign rise = rise_q;

endmodule

// File: rtl/sr_cmd_debounce.sv
// Command stage in front of the SR flip-flop: debounces the set/reset buttons and issues exclusive 1-cycle s/r pulses.
// Latency: s/r rise DEBOUNCE_CYCLES+3 edges after a clean press; set_lvl/rst_lvl lead s/r by one cycle.
// Backpressure: none; the flip-flop consumes every pulse in the cycle it appears.
//
// Ports: clk, reset (async active-low), set_btn/rst_btn (raw buttons),
//        s/r (registered command pulses, never both high), conflict (both pressed in the same cycle),
//        set_lvl/rst_lvl (debounced levels).
// Build option SR_RESET_PRIO_EN: when it is defined, a simultaneous press issues r. Otherwise both
// commands are dropped. conflict is flagged in either build.
module sr_cmd_debounce
    import sr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic rst_btn,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_lvl,
    output logic rst_lvl
);

    logic       set_rise, rst_rise;
    logic [1:0] cmd_q, cmd_d;
    logic       conflict_q, conflict_d;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (set_btn),
        .lvl     (set_lvl),
        .rise    (set_rise)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (rst_btn),
        .lvl     (rst_lvl),
        .rise    (rst_rise)
    );

    // cmd_d only ever takes the SET, RST or HOLD encodings, so the flip-flop's invalid 11 case is unreachable.
    always_comb begin
        cmd_d      = SR_CMD_HOLD;
        conflict_d = 1'b0;
        case ({set_rise, rst_rise})
            2'b10: cmd_d = SR_CMD_SET;
            2'b01: cmd_d = SR_CMD_RST;
            2'b11: begin
                conflict_d = 1'b1;
`ifdef SR_RESET_PRIO_EN
                cmd_d = SR_CMD_RST;
`else
                cmd_d = SR_CMD_HOLD;
`endif
            end
            default: cmd_d = SR_CMD_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q      <= SR_CMD_HOLD;
            conflict_q <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = cmd_q[1];
    assign r        = cmd_q[0];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce with DEBOUNCE_CYCLES=4, plus a random bounce soak.
module tb_sr_cmd_debounce;

    localparam int N = 4;

`ifdef SR_RESET_PRIO_EN
    localparam int EXP_BOTH_S = 0;
    localparam int EXP_BOTH_R = 1;
`else
    localparam int EXP_BOTH_S = 0;
    localparam int EXP_BOTH_R = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic set_btn;
    logic rst_btn;
    logic s, r, conflict, set_lvl, rst_lvl;

    always #5 clk = ~clk;

    sr_cmd_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .set_btn  (set_btn),
        .rst_btn  (rst_btn),
        .s        (s),
        .r        (r),
        .conflict (conflict),
        .set_lvl  (set_lvl),
        .rst_lvl  (rst_lvl)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling edge.
    int s_pulses = 0, r_pulses = 0, c_pulses = 0;
    int both_hi = 0, wide = 0;
    logic s_p = 1'b0, r_p = 1'b0, c_p = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            s_p = 1'b0;
            r_p = 1'b0;
            c_p = 1'b0;
        end else begin
            if (s && !s_p) s_pulses++;
            if (r && !r_p) r_pulses++;
            if (conflict && !c_p) c_pulses++;
            if (s && s_p) wide++;
            if (r && r_p) wide++;
            if (conflict && c_p) wide++;
            if (s && r) both_hi++;
            s_p = s;
            r_p = r;
            c_p = conflict;
        end
    end

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_s, base_r, base_c;

        reset   = 1'b0;
        set_btn = 1'b0;
        rst_btn = 1'b0;
        #2;
        check("rst_s", s, 0);
        check("rst_r", r, 0);
        check("rst_conflict", conflict, 0);
        check("rst_set_lvl", set_lvl, 0);
        check("rst_rst_lvl", rst_lvl, 0);
        step(2);
        reset = 1'b1;
        step(2);

        // Clean press: the button is high before edge 0.
        base_s  = s_pulses;
        set_btn = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step(1);
            if (k == 5) check("clean_lvl_e5", set_lvl, 0);
            if (k == 6) begin
                check("clean_lvl_e6", set_lvl, 1);
                check("clean_s_e6", s, 0);
            end
            if (k == 7) begin
                check("clean_s_e7", s, 1);
                check("clean_r_e7", r, 0);
                check("clean_conf_e7", conflict, 0);
            end
            if (k == 8) check("clean_s_e8", s, 0);
        end
        check("clean_count", s_pulses - base_s, 1);
        set_btn = 1'b0;
        step(12);
        check("clean_release_lvl", set_lvl, 0);

        // Bounce: 1,0,1,0, then hold 1. The final rise is before edge 4.
        base_r  = r_pulses;
        rst_btn = 1'b1; step(1);
        rst_btn = 1'b0; step(1);
        rst_btn = 1'b1; step(1);
        rst_btn = 1'b0; step(1);
        rst_btn = 1'b1;
        for (int k = 4; k <= 12; k++) begin
            step(1);
            if (k == 10) begin
                check("bounce_r_e10", r, 0);
                check("bounce_no_early", r_pulses - base_r, 0);
            end
            if (k == 11) check("bounce_r_e11", r, 1);
            if (k == 12) check("bounce_r_e12", r, 0);
        end
        step(10);
        check("bounce_count", r_pulses - base_r, 1);
        check("bounce_lvl", rst_lvl, 1);
        rst_btn = 1'b0;
        step(12);

        // Hold, then re-press.
        base_s  = s_pulses;
        set_btn = 1'b1;
        step(50);
        check("hold_one_pulse", s_pulses - base_s, 1);
        set_btn = 1'b0;
        step(10);
        set_btn = 1'b1;
        step(20);
        check("repress_two_pulses", s_pulses - base_s, 2);
        set_btn = 1'b0;
        step(12);

        // Simultaneous press.
        base_c  = c_pulses;
        set_btn = 1'b1;
        rst_btn = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step(1);
            if (k == 6) begin
                check("both_set_lvl", set_lvl, 1);
                check("both_rst_lvl", rst_lvl, 1);
            end
            if (k == 7) begin
                check("both_s", s, EXP_BOTH_S);
                check("both_r", r, EXP_BOTH_R);
                check("both_conflict", conflict, 1);
            end
            if (k == 8) begin
                check("both_conflict_e8", conflict, 0);
                check("both_r_e8", r, 0);
            end
        end
        check("both_conflict_count", c_pulses - base_c, 1);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        step(12);

        // Reset while s is high: the pulse is dropped at once.
        set_btn = 1'b1;
        step(8);
        check("inflight_s_before", s, 1);
        reset = 1'b0;
        #1;
        check("inflight_s_dropped", s, 0);
        check("inflight_lvl_cleared", set_lvl, 0);
        set_btn = 1'b0;
        step(2);
        reset  = 1'b1;
        base_s = s_pulses;
        step(15);
        check("inflight_no_refire", s_pulses - base_s, 0);

        // Reset mid-debounce with the button held through reset release.
        set_btn = 1'b1;
        step(5);
        reset = 1'b0;
        #1;
        check("middeb_lvl", set_lvl, 0);
        step(2);
        reset  = 1'b1;
        base_s = s_pulses;
        for (int k = 0; k <= 8; k++) begin
            step(1);
            if (k == 6) check("middeb_s_e6", s, 0);
            if (k == 7) check("middeb_s_e7", s, 1);
            if (k == 8) check("middeb_s_e8", s, 0);
        end
        check("middeb_count", s_pulses - base_s, 1);
        set_btn = 1'b0;
        step(12);

        // Random bounce soak.
        base_s = s_pulses;
        base_r = r_pulses;
        repeat (10000) begin
            if ($urandom_range(0, 7) == 0) set_btn = ~set_btn;
            if ($urandom_range(0, 7) == 0) rst_btn = ~rst_btn;
            step(1);
        end
        set_btn = 1'b0;
        rst_btn = 1'b0;
        step(15);
        check("soak_s_and_r", both_hi, 0);
        check("soak_pulse_width", wide, 0);
        check("soak_s_seen", int'(s_pulses > base_s), 1);
        check("soak_r_seen", int'(r_pulses > base_r), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_cmd_debounce.md
# sr_cmd_debounce

Upstream command stage for the SR flip-flop. It takes two raw, asynchronous, bouncing push-button inputs (set and reset), synchronizes and debounces each one, and detects rising edges. It then drives one-cycle `s`/`r` pulses that are guaranteed never to be high together. The block sits directly in front of the SR flip-flop and feeds its `s` and `r` inputs, so the flip-flop's invalid `11` case is unreachable by construction.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized-stable samples required to accept a level change. Legal range is 1 to 2^20.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`, minimum 1: width of the debounce counter (localparam).
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-low; clock clk.
- `set_btn`, input, 1: raw set button, asynchronous to `clk`, may bounce.
- `rst_btn`, input, 1: raw reset button, asynchronous to `clk`, may bounce.
- `s`, output, 1: registered one-cycle set pulse to the flip-flop.
- `r`, output, 1: registered one-cycle reset pulse to the flip-flop.
- `conflict`, output, 1: registered one-cycle flag; both channels accepted a rising edge in the same cycle.
- `set_lvl`, output, 1: debounced level of `set_btn`.
- `rst_lvl`, output, 1: debounced level of `rst_btn`.

## Operation
- Each channel has a 2-flop synchronizer, then a debounce FSM, then a rise strobe.
- Debounce FSM states: `IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`.
  - `IDLE_LO`: sync=1 goes to `WAIT_HI` and sets cnt=0.
  - `WAIT_HI`: sync=0 returns to `IDLE_LO`. Sync=1 with cnt==DEBOUNCE_CYCLES-1 goes to `IDLE_HI` and raises the rise strobe for one cycle. Otherwise cnt increments.
  - `IDLE_HI` and `WAIT_LO` mirror `IDLE_LO` and `WAIT_HI` with polarity inverted. No strobe is raised on the falling side.
- `set_lvl`/`rst_lvl` are 1 in `IDLE_HI` and `WAIT_LO`, and 0 otherwise.
- Arbiter (registered) acts on the two rise strobes:
  - Only set rise: s=1 for one cycle.
  - Only reset rise: r=1 for one cycle.
  - Both in the same cycle: conflict=1 for one cycle. The resolution is selected by configuration.
  - Neither: s=r=conflict=0.
- Invariant: s&r is never 1.
- The counter never wraps. It is cleared on every state entry and compared for equality only.

## Timing
- Reset values: s=0, r=0, conflict=0, set_lvl=0, rst_lvl=0. Both synchronizers are 0, both FSMs are in `IDLE_LO`, and both counters are 0.
- Latency: with a raw input high and stable from before clk edge 0, the FSM enters `WAIT_HI` at edge 2. The strobe is set at edge 2+N, where N=DEBOUNCE_CYCLES. `s`/`r` go high at edge N+3 and low at edge N+4.
- Glitch rejection: a synchronized high shorter than N+1 consecutive samples produces no pulse.
- Releasing a button needs N+1 stable low samples before it can fire again. Holding a button produces exactly one pulse.
- Reset asserted mid-count aborts the operation immediately, and any in-flight pulse is dropped.
- A button held through reset release is treated as a new press and fires once after N+3 edges.
- `set_lvl`/`rst_lvl` change on the same edge as the internal strobe, one cycle before `s`/`r`.

## Configuration
- `SR_RESET_PRIO_EN`: governs the both-rise case.
  - Defined: the reset channel wins. r=1, s=0, conflict=1.
  - Undefined: both commands are dropped. s=0, r=0, conflict=1.
- All other behaviour is identical in both builds.

## Structure
- Shared package `sr_pkg`:
  - `deb_state_t` enum holding `IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`.
  - `SR_CMD_SET=2'b10`, `SR_CMD_RST=2'b01`, `SR_CMD_HOLD=2'b00` encodings, shared with the flip-flop's case decode.
- Sub-module `sr_debounce`: synchronizer, FSM, counter, and rise strobe for one channel. It is instantiated twice. The top level holds only the arbiter and the output registers.

## Test plan
- Clean press (N=4): set_btn=1 from edge 0 gives s=1 exactly between edges 7 and 8, with r=0, conflict=0 and set_lvl=1 from edge 6.
- Bounce (N=4): rst_btn toggles 1,0,1,0 on successive cycles and then holds 1. This gives exactly one r pulse, 7 edges after the final rising transition; there is no earlier r.
- Hold and re-press: set_btn high for 50 cycles, low for 10, then high again. This gives exactly two s pulses, and s is never high during the hold.
- Simultaneous press: both buttons rise on the same edge.
  - With the macro defined: r=1, s=0, conflict=1 at edge 7.
  - With the macro undefined: s=r=0, conflict=1.
- Reset mid-debounce: assert reset at edge 4 of a set press and release at edge 6 with set_btn still high. Outputs go to 0 immediately, and a single s pulse follows at release edge +N+3.
- Random soak: 10k cycles of random bouncing on both inputs. s&r is asserted never, and every s/r/conflict pulse is exactly one cycle wide.
